interp_output_normalizer: RTL and testbench

- Sits directly downstream of the linear interpolator, in the 96 kHz output path.
- Takes the interpolator's un-normalised 34-bit L/R sums, d1*(M-a) + d0*a scaled by 1/4, and divides by the sub-sample span M.
- Produces signed 24-bit audio samples for the output serializer.
- Uses one iterative restoring divider per channel, sharing a single divisor and sequencer. This suits the 512-clock sample period.

---
 rtl/interp_pkg.sv | 44 ++++
 rtl/interp_output_normalizer_divider.sv | 44 ++++
 rtl/interp_output_normalizer.sv | 134 +++++++++++++
 tb/tb_interp_output_normalizer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared widths, saturation limits and sequencer encoding for the
// interpolator output normaliser.
package interp_pkg;

  localparam int DIN_W     = 34;
  localparam int DOUT_W    = 24;
  localparam int DIV_W     = 11;
  localparam int PRE_SHIFT = 2;
  localparam int NUM_W     = DIN_W + PRE_SHIFT;
  localparam int CNT_W     = 6;

  localparam logic [DOUT_W-1:0] SAT_POS = 24'h7FFFFF;
  localparam logic [DOUT_W-1:0] SAT_NEG = 24'h800000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DIVIDE = 2'd2,
    FINAL  = 2'd3
  } state_t;

  // |x| scaled back up by the bits the interpolator dropped
  function automatic logic [NUM_W-1:0] mag_of(
    input logic [DIN_W-1:0] x
  );
    logic [DIN_W-1:0] a;
    a = x[DIN_W-1] ? -x : x;
    return {a, {PRE_SHIFT{1'b0}}};
  endfunction

  function automatic logic [DOUT_W-1:0] sat_apply(
    input logic             neg,
    input logic [NUM_W-1:0] q
  );
    logic [DOUT_W-1:0] r;
    if (!neg) begin
      r = (q > NUM_W'(SAT_POS)) ? SAT_POS : q[DOUT_W-1:0];
    end else begin
      r = (q > NUM_W'(SAT_NEG)) ? SAT_NEG : -q[DOUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/interp_output_normalizer_divider.sv
// One channel of restoring division: one quotient bit per step, MSB
// first; the shared sequencer owns the iteration count.
module serial_udivider
  import interp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [NUM_W-1:0] numer,
  input  logic [DIV_W-1:0] divisor,
  output logic [NUM_W-1:0] quot
);

  logic [NUM_W-1:0] num_q;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W:0]   diff;
  logic             ge;

  // remainder stays below the divisor, so the difference fits DIV_W
  always_comb begin
    rem_sh = {rem_q, num_q[NUM_W-1]};
    ge     = rem_sh >= {1'b0, divisor};
    diff   = rem_sh - {1'b0, divisor};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q <= '0;
      rem_q <= '0;
      quot  <= '0;
    end else if (load) begin
      num_q <= numer;
      rem_q <= '0;
      quot  <= '0;
    end else if (step) begin
      num_q <= num_q << 1;
      quot  <= {quot[NUM_W-2:0], ge};
      rem_q <= ge ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/interp_output_normalizer.sv
// Divides interpolator L/R sums by the sub-sample span and emits
// saturated signed 24-bit samples.
module interp_output_normalizer
  import interp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              din_valid,
  input  logic [DIN_W-1:0]  l_data_in,
  input  logic [DIN_W-1:0]  r_data_in,
  input  logic [DIV_W-1:0]  max_count,
  output logic              dout_valid,
  output logic [DOUT_W-1:0] l_data_out,
  output logic [DOUT_W-1:0] r_data_out,
  output logic              div_zero,
  output logic              overrun,
  output logic [15:0]       test_data
);

  state_t state, next_state;

  logic [DIN_W-1:0] l_reg, r_reg;
  logic [DIV_W-1:0] m_reg;
  logic             l_neg, r_neg;
  logic [CNT_W-1:0] iter_cnt;
  logic [NUM_W-1:0] l_quot, r_quot;

  logic accept, load_en, step_en, final_en;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_en    = 1'b0;
    step_en    = 1'b0;
    final_en   = 1'b0;
    if (!run) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (din_valid) begin
            accept     = 1'b1;
            next_state = LOAD;
          end
        end
        LOAD: begin
          load_en    = 1'b1;
          next_state = DIVIDE;
        end
        DIVIDE: begin
          step_en = 1'b1;
          if (iter_cnt == '0) next_state = FINAL;
        end
        FINAL: begin
          final_en   = 1'b1;
          next_state = IDLE;
        end
      endcase
    end
  end

  serial_udivider u_div_l (
    .clk     (clk),
    .reset   (reset),
    .load    (load_en),
    .step    (step_en),
    .numer   (mag_of(l_reg)),
    .divisor (m_reg),
    .quot    (l_quot)
  );

  serial_udivider u_div_r (
    .clk     (clk),
    .reset   (reset),
    .load    (load_en),
    .step    (step_en),
    .numer   (mag_of(r_reg)),
    .divisor (m_reg),
    .quot    (r_quot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      l_reg      <= '0;
      r_reg      <= '0;
      m_reg      <= '0;
      l_neg      <= 1'b0;
      r_neg      <= 1'b0;
      iter_cnt   <= '0;
      l_data_out <= '0;
      r_data_out <= '0;
      dout_valid <= 1'b0;
      div_zero   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= final_en;
      div_zero   <= final_en && (m_reg == '0);
      if (run && din_valid && state != IDLE) overrun <= 1'b1;
      if (accept) begin
        l_reg <= l_data_in;
        r_reg <= r_data_in;
        m_reg <= max_count;
      end
      if (load_en) begin
        l_neg    <= l_reg[DIN_W-1];
        r_neg    <= r_reg[DIN_W-1];
        iter_cnt <= CNT_W'(NUM_W - 1);
      end
      if (step_en && iter_cnt != '0) begin
        iter_cnt <= iter_cnt - CNT_W'(1);
      end
      // a zero span bypasses the quotient and saturates by sign
      if (final_en) begin
        if (m_reg == '0) begin
          l_data_out <= l_neg ? SAT_NEG : SAT_POS;
          r_data_out <= r_neg ? SAT_NEG : SAT_POS;
        end else begin
          l_data_out <= sat_apply(l_neg, l_quot);
          r_data_out <= sat_apply(r_neg, r_quot);
        end
      end
    end
  end

  assign test_data = {state, overrun, div_zero, iter_cnt,
                      l_data_out[DOUT_W-1:DOUT_W-6]};

endmodule

// File: tb/tb_interp_output_normalizer.sv
// Scoreboard bench: expected samples queued at issue, compared with
// latency when dout_valid strobes.
module tb_interp_output_normalizer;

  logic        clk = 1'b0;
  logic        reset, run, din_valid;
  logic [33:0] l_data_in, r_data_in;
  logic [10:0] max_count;
  logic        dout_valid, div_zero, overrun;
  logic [23:0] l_data_out, r_data_out;
  logic [15:0] test_data;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          dv_count = 0;
  int          d0;
  logic [23:0] last_l = '0;
  logic [23:0] last_r = '0;

  interp_output_normalizer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .din_valid  (din_valid),
    .l_data_in  (l_data_in),
    .r_data_in  (r_data_in),
    .max_count  (max_count),
    .dout_valid (dout_valid),
    .l_data_out (l_data_out),
    .r_data_out (r_data_out),
    .div_zero   (div_zero),
    .overrun    (overrun),
    .test_data  (test_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [33:0] d,
                                        input logic [10:0] m);
    longint v, q;
    v = longint'($signed(d));
    if (m == 0) return (v < 0) ? 24'h800000 : 24'h7FFFFF;
    q = ((v < 0 ? -v : v) * 4) / longint'(m);
    if (v < 0) q = -q;
    if (q > 64'sd8388607) q = 64'sd8388607;
    if (q < -64'sd8388608) q = -64'sd8388608;
    return q[23:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    check("dz_alone", 64'(div_zero & ~dout_valid), 64'd0);
    if (dout_valid) begin
      dv_count++;
      if (sb.size() == 0) begin
        check("spurious_dv", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("l_out", 64'(l_data_out), 64'(e.l));
        check("r_out", 64'(r_data_out), 64'(e.r));
        check("div_zero", 64'(div_zero), 64'(e.dz));
        check("latency", 64'(cyc), 64'(e.cyc));
        last_l = e.l;
        last_r = e.r;
      end
    end
  end

  task automatic send(input logic [33:0] l, input logic [33:0] r,
                      input logic [10:0] m, input bit acc);
    exp_t e;
    @(negedge clk);
    din_valid = 1'b1;
    l_data_in = l;
    r_data_in = r;
    max_count = m;
    if (acc) begin
      e.l   = model(l, m);
      e.r   = model(r, m);
      e.dz  = (m == 0);
      e.cyc = cyc + 1 + 38;
      sb.push_back(e);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", sb.size());
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    run = 1'b1;
    din_valid = 1'b0;
    l_data_in = '0;
    r_data_in = '0;
    max_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_l", 64'(l_data_out), 64'd0);
    check("rst_r", 64'(r_data_out), 64'd0);
    check("rst_dv", 64'(dout_valid), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    check("rst_test", 64'(test_data), 64'd0);

    send(34'h0008000000, 34'h0008000000, 11'd512, 1);
    wait_done();
    check("t1_ovr", 64'(overrun), 64'd0);
    send(-34'h0008000000, -34'd5, 11'd8, 1);
    wait_done();
    send(-34'h0000200000, 34'd20, 11'd8, 1);
    wait_done();
    send(34'h100000000, -34'h100000000, 11'd1, 1);
    wait_done();
    send(34'h123, -34'd1, 11'd0, 1);
    wait_done();
    send(34'd0, 34'd0, 11'd0, 1);
    wait_done();
    send(34'd0, -34'd0, 11'd5, 1);
    wait_done();
    send(34'h7FFFFF, -34'h800000, 11'd4, 1);
    wait_done();
    send(34'h800000, -34'h800001, 11'd4, 1);
    wait_done();
    send(34'h1FFFFFFFF, -34'h1FFFFFFFF, 11'd2047, 1);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      logic [33:0] a, b;
      a = 34'({$urandom, $urandom});
      b = 34'({$urandom, $urandom});
      a = 34'($signed(a) >>> $urandom_range(8, 33));
      b = 34'($signed(b) >>> $urandom_range(8, 33));
      send(a, b, 11'($urandom_range(1, 2047)), 1);
      wait_done();
    end
    check("ovr_before", 64'(overrun), 64'd0);

    send(34'h0008000000, 34'h0008000000, 11'd512, 1);
    repeat (9) @(negedge clk);
    send(34'd0, 34'd0, 11'd512, 0);
    check("ovr_set", 64'(overrun), 64'd1);
    wait_done();
    repeat (5) @(negedge clk);
    check("ovr_sticky", 64'(overrun), 64'd1);
    check("ovr_test", 64'(test_data[13]), 64'd1);

    pulse_reset();
    check("ovr_clr", 64'(overrun), 64'd0);
    check("rst2_l", 64'(l_data_out), 64'd0);

    send(34'h0000400000, -34'h0000400000, 11'd16, 1);
    repeat (36) @(negedge clk);
    send(34'h1234, 34'h1234, 11'd3, 0);
    check("final_drop_ovr", 64'(overrun), 64'd1);
    wait_done();

    pulse_reset();
    send(34'h0008000000, 34'h0008000000, 11'd512, 0);
    repeat (19) @(negedge clk);
    pulse_reset();
    check("abort_l", 64'(l_data_out), 64'd0);
    check("abort_r", 64'(r_data_out), 64'd0);
    d0 = dv_count;
    repeat (45) @(negedge clk);
    check("abort_no_dv", 64'(dv_count), 64'(d0));
    send(34'h0000300000, -34'h0000300000, 11'd6, 1);
    wait_done();

    send(34'h0008000000, -34'd77, 11'd9, 0);
    repeat (19) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    check("run_hold_l", 64'(l_data_out), 64'(last_l));
    check("run_hold_r", 64'(r_data_out), 64'(last_r));
    check("run_idle", 64'(test_data[15:14]), 64'd0);
    d0 = dv_count;
    repeat (45) @(negedge clk);
    check("run_no_dv", 64'(dv_count), 64'(d0));
    send(-34'h0000000007, 34'h0000000007, 11'd3, 1);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
